// File: rtl/citi_sample_sequencer.sv
// Sample-rate stimulus/capture engine for the citi IIR filter: replays a small
// sample memory into xin and records sign-extended yout into a host-readable buffer.
module citi_sample_sequencer #(
  parameter int N      = 8,
  parameter int AW     = 3,
  parameter int DIV    = 30,
  parameter int PASSES = 3,
  parameter int LAT    = 2
) (
  input  logic          clk30x,
  input  logic          rst,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  input  logic          start,
  output logic [15:0]   xin,
  input  logic [15:0]   yout,
  output logic          sample_stb,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  output logic          busy,
  output logic          done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = $clog2(PASSES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   pass_cnt_q, pass_cnt_d;
  logic [15:0]     xin_q;
  logic            stb_q;
  logic [31:0]     rd_data_q;
  logic [31:0]     res_q [N];
  logic [15:0]     smem_q [N];

  logic            boundary, last;
  logic [AW-1:0]   wr_slot;
  logic [31:0]     res_d;

  always_comb begin
    boundary   = (state_q == RUN) && (div_cnt_q == DW'(DIV - 1));
    last       = boundary && (idx_q == AW'(N - 1)) && (pass_cnt_q == PW'(PASSES - 1));
    div_cnt_d  = boundary ? '0 : div_cnt_q + 1'b1;
    idx_d      = idx_q + 1'b1;
    pass_cnt_d = (idx_q == AW'(N - 1)) ? pass_cnt_q + 1'b1 : pass_cnt_q;
    // N is a power of two, so the address subtraction wraps modulo N for free.
    wr_slot    = idx_q - AW'(LAT);
    res_d      = {{16{yout[15]}}, yout};
  end

  always_ff @(posedge clk30x) begin
    if (rst) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      idx_q      <= '0;
      pass_cnt_q <= '0;
      xin_q      <= '0;
      stb_q      <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < N; i++) res_q[i] <= '0;
    end else begin
      rd_data_q <= res_q[rd_addr];
      stb_q     <= boundary;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= RUN;
            div_cnt_q  <= '0;
            idx_q      <= '0;
            pass_cnt_q <= '0;
          end
        end
        RUN: begin
          div_cnt_q <= div_cnt_d;
          if (boundary) begin
            xin_q          <= smem_q[idx_q];
            res_q[wr_slot] <= res_d;
            idx_q          <= idx_d;
            pass_cnt_q     <= pass_cnt_d;
            if (last) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sample memory keeps its contents across reset; only writable outside a run.
  always_ff @(posedge clk30x) begin
    if (!rst && load_we && state_q != RUN) smem_q[load_addr] <= load_data;
  end

  assign xin        = xin_q;
  assign sample_stb = stb_q;
  assign rd_data    = rd_data_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);

endmodule
